// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_pkg
//   Shared constants and helpers for the multiplexed 7-segment scan logic.
//   DIGIT_W    : bits per BCD digit
//   BCD_MAX    : largest nibble value the external decoder renders correctly
//   MAX_DIGITS : widest digit select any scan controller may drive
//   onehot_sel : index -> one-hot digit enable (MAX_DIGITS wide)
//   nibble_is_bcd : true when a nibble is a legal decimal digit
// -----------------------------------------------------------------------------
package display_scan_ctrl_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;
  localparam int         SEL_IDX_W  = 3;

  // One-hot digit enable; callers slice the low NUM_DIGITS bits.
  function automatic logic [MAX_DIGITS-1:0] onehot_sel(input logic [SEL_IDX_W-1:0] idx);
    logic [MAX_DIGITS-1:0] oh;
    oh      = {MAX_DIGITS{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // The decoder latches its previous pattern for 10..15, so these must be blanked.
  function automatic logic nibble_is_bcd(input logic [DIGIT_W-1:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
//   Free-running divider producing a single-cycle tick every DIV clocks.
//   The counter runs 0..DIV-1; tick is combinational and high while the count
//   equals DIV-1, so the first tick edge lands DIV cycles after reset releases.
//   Ports:
//     clk   in  system clock, rising edge
//     reset in  synchronous reset, active-high
//     tick  out one-cycle strobe (combinational from the count register)
// -----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int               CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_s;

  // Next count: wrap at DIV-1, otherwise increment.
  always_comb begin
    last_s = (cnt_q == CNT_LAST);
    if (last_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = last_s;

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexes one external BCD-to-7-segment decoder across NUM_DIGITS
//   digit positions. A new value is taken through a valid/ready handshake into
//   a pending register and copied into the displayed (shadow) register only on
//   the tick that closes the last digit slot, so a frame never mixes values.
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   synchronous reset, active-high
//     value_in   in   packed BCD, nibble 0 = least-significant digit
//     load_valid in   value_in valid, held until accepted
//     load_ready out  high when no load is pending
//     lz_en      in   leading-zero suppression enable
//     blink_en   in   whole-display blink enable
//     dec_n      out  nibble to the decoder
//     dec_off    out  decoder blank (1 = segments off)
//     digit_sel  out  one-hot digit enable, zero in reset
//     frame_done out  one-cycle pulse after the last slot's tick edge
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic                          lz_en,
  input  logic                          blink_en,
  output logic [DIGIT_W-1:0]            dec_n,
  output logic                          dec_off,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_done
);

  localparam int VAL_W = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BLK_W-1:0]   BLK_ZERO = {BLK_W{1'b0}};
  localparam logic [BLK_W-1:0]   BLK_ONE  = BLK_W'(1);
  localparam logic [VAL_W-1:0]   VAL_ZERO = {VAL_W{1'b0}};
  localparam logic [DIGIT_W-1:0] NIB_ZERO = {DIGIT_W{1'b0}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      idx_q,         idx_d;
  logic [VAL_W-1:0]      shadow_q,      shadow_d;
  logic [VAL_W-1:0]      pend_q,        pend_d;
  logic                  pending_q,     pending_d;
  logic [BLK_W-1:0]      blink_cnt_q,   blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [DIGIT_W-1:0]    dec_n_q,       dec_n_d;
  logic                  dec_off_q,     dec_off_d;
  logic [NUM_DIGITS-1:0] digit_sel_q,   digit_sel_d;
  logic                  frame_done_q,  frame_done_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                  tick_s;
  logic                  frame_end_s;
  logic                  accept_s;
  logic [DIGIT_W-1:0]    cur_nib_s;
  logic                  upper_zero_s;
  logic                  blank_s;
  logic [MAX_DIGITS-1:0] oh_s;

  scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign frame_end_s = tick_s && (idx_q == IDX_LAST);
  // ready is ~pending, so an accept can never coincide with a commit.
  assign accept_s    = load_valid && !pending_q;

  // Select the current slot's nibble and test whether it and every more
  // significant nibble are zero (the leading-zero condition).
  always_comb begin
    cur_nib_s    = NIB_ZERO;
    upper_zero_s = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j == int'(idx_q)) begin
        cur_nib_s = shadow_q[j*DIGIT_W +: DIGIT_W];
      end else begin
        cur_nib_s = cur_nib_s;
      end
      if ((j >= int'(idx_q)) && (shadow_q[j*DIGIT_W +: DIGIT_W] != NIB_ZERO)) begin
        upper_zero_s = 1'b0;
      end else begin
        upper_zero_s = upper_zero_s;
      end
    end
  end

  // Blank for illegal nibbles, suppressed leading zeros (digit 0 is always
  // shown so a zero value reads "0"), or the blink off phase.
  always_comb begin
    blank_s = !nibble_is_bcd(cur_nib_s)
            | (lz_en && (idx_q != IDX_ZERO) && upper_zero_s)
            | (blink_en && blink_phase_q);
    oh_s    = onehot_sel(SEL_IDX_W'(idx_q));
  end

  // Next-state logic for scan, handshake, commit and blink.
  always_comb begin
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;
    pending_d     = pending_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    dec_n_d       = dec_n_q;
    dec_off_d     = dec_off_q;
    digit_sel_d   = digit_sel_q;
    frame_done_d  = 1'b0;

    // Capture a new value into the pending register.
    if (accept_s) begin
      pend_d    = value_in;
      pending_d = 1'b1;
    end else begin
      pend_d    = pend_q;
    end

    // Advance the scan; all visible outputs update together on the tick.
    if (tick_s) begin
      digit_sel_d = oh_s[NUM_DIGITS-1:0];
      dec_n_d     = cur_nib_s;
      dec_off_d   = blank_s;
      if (idx_q == IDX_LAST) begin
        idx_d = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      idx_d = idx_q;
    end

    // Frame boundary: pulse frame_done and commit any pending value so the
    // next slot (digit 0) already shows it.
    if (frame_end_s) begin
      frame_done_d = 1'b1;
      if (pending_q) begin
        shadow_d  = pend_q;
        pending_d = 1'b0;
      end else begin
        shadow_d  = shadow_q;
      end
    end else begin
      frame_done_d = 1'b0;
    end

    // Blink half-period counter, held cleared while blinking is disabled.
    if (!blink_en) begin
      blink_cnt_d   = BLK_ZERO;
      blink_phase_d = 1'b0;
    end else if (frame_end_s) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = BLK_ZERO;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLK_ONE;
      end
    end else begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
    end
  end

  // State and output registers; reset discards any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= IDX_ZERO;
      shadow_q      <= VAL_ZERO;
      pend_q        <= VAL_ZERO;
      pending_q     <= 1'b0;
      blink_cnt_q   <= BLK_ZERO;
      blink_phase_q <= 1'b0;
      dec_n_q       <= NIB_ZERO;
      dec_off_q     <= 1'b1;
      digit_sel_q   <= {NUM_DIGITS{1'b0}};
      frame_done_q  <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      pending_q     <= pending_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      dec_n_q       <= dec_n_d;
      dec_off_q     <= dec_off_d;
      digit_sel_q   <= digit_sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign load_ready = !pending_q;
  assign dec_n      = dec_n_q;
  assign dec_off    = dec_off_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Directed bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4,
//   BLINK_FRAMES=2. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk;
  logic          reset;
  logic [15:0]   value_in;
  logic          load_valid;
  logic          load_ready;
  logic          lz_en;
  logic          blink_en;
  logic [3:0]    dec_n;
  logic          dec_off;
  logic [ND-1:0] digit_sel;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .lz_en      (lz_en),
    .blink_en   (blink_en),
    .dec_n      (dec_n),
    .dec_off    (dec_off),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the visible outputs of the slot just entered.
  task automatic chk_out(input string tag, input logic [3:0] sel, input logic [3:0] n, input logic off);
    chk({tag, "_sel"}, 32'(digit_sel), 32'(sel));
    chk({tag, "_n"},   32'(dec_n),     32'(n));
    chk({tag, "_off"}, 32'(dec_off),   32'(off));
    chk({tag, "_fd"},  32'(frame_done), 32'(sel == 4'b1000));
  endtask

  task automatic slot_chk(input string tag, input logic [3:0] sel, input logic [3:0] n, input logic off);
    repeat (SD) step();
    chk_out(tag, sel, n, off);
  endtask

  // One full frame starting from a frame-end point; offs bit s = dec_off of slot s.
  task automatic show_frame(input string tag, input logic [15:0] v, input logic [3:0] offs);
    logic [3:0] sel;
    for (int s = 0; s < ND; s++) begin
      sel = 4'b0001 << s;
      slot_chk($sformatf("%s_d%0d", tag, s), sel, v[s*4 +: 4], offs[s]);
    end
  endtask

  // Load a value from a frame-end point; it is committed at the next frame end.
  task automatic load_val(input string tag, input logic [15:0] v);
    value_in   = v;
    load_valid = 1'b1;
    chk({tag, "_rdy_pre"}, 32'(load_ready), 32'd1);
    step();
    chk({tag, "_rdy_acc"}, 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    repeat (4*SD - 1) step();
    chk({tag, "_commit_fd"}, 32'(frame_done), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    value_in   = 16'h0000;
    load_valid = 1'b0;
    lz_en      = 1'b0;
    blink_en   = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_sel", 32'(digit_sel),  32'd0);
    chk("rst_off", 32'(dec_off),    32'd1);
    chk("rst_n",   32'(dec_n),      32'd0);
    chk("rst_fd",  32'(frame_done), 32'd0);
    chk("rst_rdy", 32'(load_ready), 32'd1);

    // Test 1: load 0x1234, first frame still shows zeros
    reset      = 1'b0;
    value_in   = 16'h1234;
    load_valid = 1'b1;
    chk("t1_rdy_pre", 32'(load_ready), 32'd1);
    step();
    chk("t1_rdy_acc", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    repeat (SD - 1) step();
    chk_out("t1a_d0", 4'b0001, 4'd0, 1'b0);
    slot_chk("t1a_d1", 4'b0010, 4'd0, 1'b0);
    slot_chk("t1a_d2", 4'b0100, 4'd0, 1'b0);
    slot_chk("t1a_d3", 4'b1000, 4'd0, 1'b0);
    step();
    chk("t1_fd_low", 32'(frame_done), 32'd0);
    chk("t1_rdy_back", 32'(load_ready), 32'd1);
    repeat (SD - 1) step();
    chk_out("t1b_d0", 4'b0001, 4'd4, 1'b0);
    slot_chk("t1b_d1", 4'b0010, 4'd3, 1'b0);
    slot_chk("t1b_d2", 4'b0100, 4'd2, 1'b0);
    slot_chk("t1b_d3", 4'b1000, 4'd1, 1'b0);

    // Test 2: leading-zero suppression
    lz_en = 1'b1;
    load_val("t2a", 16'h0050);
    show_frame("t2a", 16'h0050, 4'b1100);
    load_val("t2b", 16'h0000);
    show_frame("t2b", 16'h0000, 4'b1110);

    // Test 3: non-BCD nibble blanked, 9 shown
    lz_en = 1'b0;
    load_val("t3", 16'h9A01);
    show_frame("t3", 16'h9A01, 4'b0100);

    // Test 4: load A mid-frame, load B held valid
    repeat (5) step();
    value_in   = 16'h5678;
    load_valid = 1'b1;
    step();
    chk("t4_rdy_a", 32'(load_ready), 32'd0);
    value_in = 16'h4321;
    repeat (9) step();
    chk("t4_rdy_hold", 32'(load_ready), 32'd0);
    step();
    chk("t4_rdy_fe", 32'(load_ready), 32'd1);
    chk("t4_fd_fe",  32'(frame_done), 32'd1);
    step();
    chk("t4_rdy_b", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    repeat (SD - 1) step();
    chk_out("t4a_d0", 4'b0001, 4'd8, 1'b0);
    slot_chk("t4a_d1", 4'b0010, 4'd7, 1'b0);
    slot_chk("t4a_d2", 4'b0100, 4'd6, 1'b0);
    slot_chk("t4a_d3", 4'b1000, 4'd5, 1'b0);
    show_frame("t4b", 16'h4321, 4'b0000);

    // Test 5: blinking, 2 frames on / 2 frames off
    load_val("t5", 16'h1111);
    blink_en = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      show_frame($sformatf("t5f%0d", f), 16'h1111, ((f == 3) || (f == 4)) ? 4'hF : 4'h0);
    end
    slot_chk("t5f7_d0", 4'b0001, 4'd1, 1'b1);
    slot_chk("t5f7_d1", 4'b0010, 4'd1, 1'b1);
    blink_en = 1'b0;
    slot_chk("t5f7_d2", 4'b0100, 4'd1, 1'b0);
    slot_chk("t5f7_d3", 4'b1000, 4'd1, 1'b0);

    // Test 6: reset during slot 2 with a load pending
    value_in   = 16'h7777;
    load_valid = 1'b1;
    step();
    chk("t6_rdy_acc", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    repeat (12) step();
    chk("t6_pre_sel", 32'(digit_sel), 32'h4);
    reset = 1'b1;
    step();
    chk("t6_rst_sel", 32'(digit_sel),  32'd0);
    chk("t6_rst_off", 32'(dec_off),    32'd1);
    chk("t6_rst_n",   32'(dec_n),      32'd0);
    chk("t6_rst_rdy", 32'(load_ready), 32'd1);
    chk("t6_rst_fd",  32'(frame_done), 32'd0);
    reset = 1'b0;
    show_frame("t6a", 16'h0000, 4'b0000);
    show_frame("t6b", 16'h0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
